// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings and mul/div FSM state type for the hazard unit
package riscv_pkg;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_t;

endpackage

// File: rtl/riscv_md_sequencer.sv
// rtl/riscv_md_sequencer.sv - mul/div occupancy FSM; keeps a mul/div instr in E for MD_LATENCY cycles
module riscv_md_sequencer
  import riscv_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_md_op_e,
  input  logic i_mem_wait,
  output logic o_md_hold,
  output logic o_md_busy,
  output logic o_md_done
);

  localparam int CW = (MD_LATENCY > 3) ? $clog2(MD_LATENCY - 1) : 1;

  md_state_t         r_state;
  logic [CW-1:0]     r_cnt;
  logic              w_start;

  assign w_start   = (r_state == MD_IDLE) && i_md_op_e && !i_mem_wait;
  assign o_md_hold = (r_state == MD_BUSY) || w_start;
  assign o_md_busy = (r_state != MD_IDLE) || w_start;
  assign o_md_done = (r_state == MD_DONE);

  // cnt holds the number of BUSY cycles still to run; everything freezes while dmem waits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else if (!i_mem_wait) begin
      case (r_state)
        MD_IDLE: begin
          if (i_md_op_e) begin
            r_cnt   <= CW'(MD_LATENCY - 2);
            r_state <= (MD_LATENCY == 2) ? MD_DONE : MD_BUSY;
          end
        end
        MD_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) r_state <= MD_DONE;
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// rtl/riscv_hazard_ctrl.sv - 5-stage hazard unit: forwarding, load-use, redirect, mul/div and dmem wait; PERF_CNT_EN adds a stall counter
module riscv_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic [1:0]            result_src_e,
  input  logic [1:0]            pc_src_e,
  input  logic                  md_op_e,
  input  logic                  mem_req_m,
  input  logic                  mem_ready_m,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic                  flush_w,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  md_busy,
  output logic                  md_done
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cnt
`endif
);

  logic w_mem_wait;
  logic w_md_hold;
  logic w_md_busy;
  logic w_md_done;
  logic w_lu;
  logic w_redirect;

  assign w_mem_wait = mem_req_m && !mem_ready_m;
  assign w_lu       = (result_src_e == RESULT_SRC_LOAD) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign w_redirect = (pc_src_e != 2'b00);

  riscv_md_sequencer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_md_op_e  (md_op_e),
    .i_mem_wait (w_mem_wait),
    .o_md_hold  (w_md_hold),
    .o_md_busy  (w_md_busy),
    .o_md_done  (w_md_done)
  );

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input logic [REG_ADDR_W-1:0] dm,
                                         input logic                  wm,
                                         input logic [REG_ADDR_W-1:0] dw,
                                         input logic                  ww);
    if (wm && (dm != '0) && (src == dm))      return FWD_M;
    else if (ww && (dw != '0) && (src == dw)) return FWD_W;
    else                                      return FWD_REG;
  endfunction

  // Everything is forced low while reset is asserted, even with live inputs
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    flush_w     = 1'b0;
    forward_a_e = FWD_REG;
    forward_b_e = FWD_REG;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    if (rst_n) begin
      forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
      md_busy     = w_md_busy;
      md_done     = w_md_done;
      if (w_mem_wait) begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
      end else if (w_md_hold) begin
        {stall_f, stall_d, stall_e} = 3'b111;
        flush_m = 1'b1;
      end else if (w_lu && w_redirect) begin
        // the redirect discards the stalled D instr, so no stall is needed
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (w_lu) begin
        {stall_f, stall_d} = 2'b11;
        flush_e = 1'b1;
      end else if (w_redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)       r_perf_cnt <= '0;
    else if (stall_f) r_perf_cnt <= r_perf_cnt + CNT_W'(1);
  end

  assign perf_stall_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb/tb_riscv_hazard_ctrl.sv - directed self-checking bench for riscv_hazard_ctrl (MD_LATENCY 4 and 2)
module tb_riscv_hazard_ctrl;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          reg_write_m, reg_write_w;
  logic [1:0]    result_src_e, pc_src_e;
  logic          md_op_e, mem_req_m, mem_ready_m;

  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_m, flush_w;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          md_busy, md_done;

  logic          l2_stall_f, l2_stall_d, l2_stall_e, l2_stall_m;
  logic          l2_flush_d, l2_flush_e, l2_flush_m, l2_flush_w;
  logic [1:0]    l2_fa, l2_fb;
  logic          l2_busy, l2_done;

`ifdef PERF_CNT_EN
  logic [3:0]    perf_stall_cnt;
  logic [31:0]   l2_perf;
`endif

  riscv_hazard_ctrl #(
    .REG_ADDR_W (AW),
    .MD_LATENCY (4)
`ifdef PERF_CNT_EN
    ,
    .CNT_W      (4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e), .md_op_e(md_op_e),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .md_busy(md_busy), .md_done(md_done)
`ifdef PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  riscv_hazard_ctrl #(
    .REG_ADDR_W (AW),
    .MD_LATENCY (2)
  ) dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e), .md_op_e(md_op_e),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_f(l2_stall_f), .stall_d(l2_stall_d), .stall_e(l2_stall_e), .stall_m(l2_stall_m),
    .flush_d(l2_flush_d), .flush_e(l2_flush_e), .flush_m(l2_flush_m), .flush_w(l2_flush_w),
    .forward_a_e(l2_fa), .forward_b_e(l2_fb),
    .md_busy(l2_busy), .md_done(l2_done)
`ifdef PERF_CNT_EN
    ,
    .perf_stall_cnt(l2_perf)
`endif
  );

  logic [3:0]  w_stall, w_flush;
  logic [13:0] w_all;
  assign w_stall = {stall_f, stall_d, stall_e, stall_m};
  assign w_flush = {flush_d, flush_e, flush_m, flush_w};
  assign w_all   = {w_stall, w_flush, forward_a_e, forward_b_e, md_busy, md_done};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [3:0] es, input logic [3:0] ef);
    check({tag, " stall"}, 32'(w_stall), 32'(es));
    check({tag, " flush"}, 32'(w_flush), 32'(ef));
  endtask

  task automatic idle_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_m = 1'b0; reg_write_w = 1'b0;
    result_src_e = 2'b00; pc_src_e = 2'b00;
    md_op_e = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
  endtask

  initial begin
    // reset with live hazards on the inputs: everything must stay low
    idle_inputs();
    rst_n = 1'b0;
    mem_req_m = 1'b1; rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
    md_op_e = 1'b1; pc_src_e = 2'b01;
    @(negedge clk); @(negedge clk); #1;
    check("rst_all", 32'(w_all), 32'd0);
    check("rst_l2_busy", 32'(l2_busy), 32'd0);

    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    check_ctl("post_rst", 4'b0000, 4'b0000);

    // forwarding
    rd_m = 5'd5; reg_write_m = 1'b1; rs1_e = 5'd5; rd_w = 5'd5; reg_write_w = 1'b1; #1;
    check("fwd_m_wins", 32'(forward_a_e), 32'h2);
    rd_m = 5'd0; #1;
    check("fwd_w_rdm0", 32'(forward_a_e), 32'h1);
    rs2_e = 5'd5; reg_write_w = 1'b0; #1;
    check("fwd_b_none", 32'(forward_b_e), 32'h0);
    rd_m = 5'd3; reg_write_m = 1'b1; rs1_e = 5'd3; mem_req_m = 1'b1; mem_ready_m = 1'b0; #1;
    check("fwd_in_stall", 32'(forward_a_e), 32'h2);
    check_ctl("memwait", 4'b1111, 4'b0001);
    idle_inputs();
    @(negedge clk); #1;

    // load-use and redirect
    result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7; #1;
    check_ctl("lu", 4'b1100, 4'b0100);
    rd_e = 5'd0; #1;
    check_ctl("lu_rd0", 4'b0000, 4'b0000);
    rd_e = 5'd7; pc_src_e = 2'b01; #1;
    check_ctl("lu_redir", 4'b0000, 4'b1100);
    result_src_e = 2'b00; #1;
    check_ctl("redir", 4'b0000, 4'b1100);
    idle_inputs();
    @(negedge clk); #1;

    // mul/div, MD_LATENCY=4, load-use ignored while held
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      md_op_e = 1'b1;
      if (c == 1) begin result_src_e = 2'b01; rd_e = 5'd9; rs1_d = 5'd9; end
      #1;
      if (c < 3) check_ctl($sformatf("md4_c%0d", c), 4'b1110, 4'b0010);
      else       check_ctl($sformatf("md4_c%0d", c), 4'b0000, 4'b0000);
      check($sformatf("md4_done_c%0d", c), 32'(md_done), (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("md4_busy_c%0d", c), 32'(md_busy), 32'd1);
      @(negedge clk);
    end
    idle_inputs(); #1;
    check("md4_idle", 32'(md_busy), 32'd0);
    @(negedge clk);

    // mul/div, MD_LATENCY=2
    md_op_e = 1'b1; #1;
    check("md2_c0_hold", 32'(l2_stall_e), 32'd1);
    check("md2_c0_done", 32'(l2_done), 32'd0);
    @(negedge clk); #1;
    check("md2_c1_hold", 32'(l2_stall_e), 32'd0);
    check("md2_c1_done", 32'(l2_done), 32'd1);
    @(negedge clk);
    md_op_e = 1'b0; #1;
    check("md2_idle", 32'(l2_busy), 32'd0);
    @(negedge clk); @(negedge clk); #1;
    check("md4_drain", 32'(md_busy), 32'd0);
    @(negedge clk);

    // dmem wait while BUSY with a pending redirect
    md_op_e = 1'b1; #1;
    check_ctl("mw_c0", 4'b1110, 4'b0010);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      mem_req_m = 1'b1; mem_ready_m = 1'b0; pc_src_e = 2'b01; #1;
      check_ctl($sformatf("mw_wait%0d", k), 4'b1111, 4'b0001);
      check($sformatf("mw_busy%0d", k), 32'(md_busy), 32'd1);
      @(negedge clk);
    end
    mem_ready_m = 1'b1; pc_src_e = 2'b00; #1;
    check_ctl("mw_c4", 4'b1110, 4'b0010);
    @(negedge clk); #1;
    check_ctl("mw_c5", 4'b1110, 4'b0010);
    @(negedge clk); #1;
    check_ctl("mw_c6", 4'b0000, 4'b0000);
    check("mw_done", 32'(md_done), 32'd1);
    @(negedge clk);
    idle_inputs(); #1;
    check("mw_idle", 32'(md_busy), 32'd0);
    @(negedge clk);

    // reset mid-BUSY, then a full fresh sequence
    md_op_e = 1'b1; #1;
    @(negedge clk); #1;
    check("rb_busy", 32'(md_busy), 32'd1);
    rst_n = 1'b0; #1;
    check("rb_in_rst", 32'(w_all), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; md_op_e = 1'b0; #1;
    check("rb_after", 32'(w_all), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      md_op_e = 1'b1; #1;
      check($sformatf("rb_hold_c%0d", c), 32'(stall_e), (c < 3) ? 32'd1 : 32'd0);
      check($sformatf("rb_done_c%0d", c), 32'(md_done), (c == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    idle_inputs(); #1;
    check("rb_idle", 32'(md_busy), 32'd0);

`ifdef PERF_CNT_EN
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("perf_rst", 32'(perf_stall_cnt), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      mem_req_m = 1'b1; mem_ready_m = 1'b0;
      @(negedge clk);
    end
    idle_inputs(); #1;
    check("perf_wrap", 32'(perf_stall_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
